// File: rtl/gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gate_bist_ctrl
//  Purpose  : Built-in self-test sequencer for four two-input gates
//             (nand, nor, xor, xnor). Applies the four input combinations
//             00,01,10,11 on {a,b}, holds each for SETTLE_CYCLES cycles,
//             then compares every enabled gate output against its golden
//             value and accumulates the mismatch count.
//  Ports    :
//    clk                 - single clock, rising edge
//    rst                 - synchronous active-high reset
//    start               - request a run (sampled only while idle)
//    op_mask[3:0]        - gates to check: 0 nand, 1 nor, 2 xor, 3 xnor
//    a, b                - stimulus to the gates under test
//    y_nand..y_xnor      - gate outputs under test
//    busy                - run in progress
//    done                - one-cycle completion pulse
//    pass                - run result, valid from done until next start
//    fail_cnt[4:0]       - mismatches in the last run (0..16)
//    err_valid/err_op/err_vec - first mismatch of the run
//                          (present only with GATE_BIST_ERRLOG_EN defined)
//  Config   : define GATE_BIST_ERRLOG_EN to add the first-error log.
//  Revision : 1.0 - initial release
// ============================================================================
module gate_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] op_mask,
  output logic       a,
  output logic       b,
  input  logic       y_nand,
  input  logic       y_nor,
  input  logic       y_xor,
  input  logic       y_xnor,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] fail_cnt
`ifdef GATE_BIST_ERRLOG_EN
  ,
  output logic       err_valid,
  output logic [1:0] err_op,
  output logic [1:0] err_vec
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic       accept;
  logic [1:0] vec;
  logic [3:0] settle_cnt;
  logic [3:0] mask_q;
  logic [3:0] mis;
  logic [2:0] mis_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and stimulus decode
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    a       = 1'b0;
    b       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        {a, b} = vec;
        if (settle_cnt == SETTLE_LAST) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        {a, b}  = vec;
        state_d = (vec == 2'd3) ? DONE : SETTLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Per-gate mismatch against golden, restricted to the latched mask.
  // {a,b} == vec while checking, so vec[1] is a and vec[0] is b.
  assign mis[0] = mask_q[0] & (y_nand != ~(vec[1] & vec[0]));
  assign mis[1] = mask_q[1] & (y_nor  != ~(vec[1] | vec[0]));
  assign mis[2] = mask_q[2] & (y_xor  !=  (vec[1] ^ vec[0]));
  assign mis[3] = mask_q[3] & (y_xnor != ~(vec[1] ^ vec[0]));

  assign mis_cnt = {2'b00, mis[0]} + {2'b00, mis[1]}
                 + {2'b00, mis[2]} + {2'b00, mis[3]};

  // Status outputs are registered one cycle behind the state so that done
  // lands on the edge that leaves DONE and busy spans SETTLE/CHECK cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec        <= 2'd0;
      settle_cnt <= 4'd0;
      mask_q     <= 4'd0;
      fail_cnt   <= 5'd0;
      pass       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state_q == DONE);
      busy <= (state_q == SETTLE) || (state_q == CHECK);
      case (state_q)
        IDLE: begin
          if (accept) begin
            mask_q     <= op_mask;
            fail_cnt   <= 5'd0;
            pass       <= 1'b0;
            vec        <= 2'd0;
            settle_cnt <= 4'd0;
          end
        end
        SETTLE: begin
          settle_cnt <= (settle_cnt == SETTLE_LAST) ? 4'd0 : settle_cnt + 4'd1;
        end
        CHECK: begin
          fail_cnt <= fail_cnt + {2'b00, mis_cnt};
          if (vec != 2'd3) begin
            vec <= vec + 2'd1;
          end
        end
        DONE: begin
          pass <= (fail_cnt == 5'd0);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef GATE_BIST_ERRLOG_EN
  logic [1:0] first_op;

  // Lowest-index mismatching gate in the current check
  always_comb begin
    first_op = 2'd3;
    if (mis[0]) begin
      first_op = 2'd0;
    end else if (mis[1]) begin
      first_op = 2'd1;
    end else if (mis[2]) begin
      first_op = 2'd2;
    end
  end

  // Captures only the first mismatch; vectors are checked in ascending
  // order so the first capture is also the earliest vec.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_op    <= 2'd0;
      err_vec   <= 2'd0;
    end else if (accept) begin
      err_valid <= 1'b0;
      err_op    <= 2'd0;
      err_vec   <= 2'd0;
    end else if ((state_q == CHECK) && !err_valid && (mis != 4'd0)) begin
      err_valid <= 1'b1;
      err_op    <= first_op;
      err_vec   <= vec;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate_bist_ctrl
//  Purpose  : Self-checking bench for gate_bist_ctrl. Emulates the gates
//             under test with configurable faults (correct, stuck-at-0,
//             stuck-at-1, inverted) and checks run results, timing, the
//             stimulus sequence and reset behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gate_bist_ctrl;

  localparam int SC      = 1;
  localparam int RUN_LEN = 4 * (SC + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] op_mask;
  logic       a, b;
  logic       y_nand, y_nor, y_xor, y_xnor;
  logic       busy, done, pass;
  logic [4:0] fail_cnt;
  logic [7:0] flt;  // two bits per gate: 0 ok, 1 stuck0, 2 stuck1, 3 inverted
`ifdef GATE_BIST_ERRLOG_EN
  logic       err_valid;
  logic [1:0] err_op, err_vec;
`endif

  int vectors    = 0;
  int miscompares = 0;

  gate_bist_ctrl #(.SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .op_mask(op_mask),
    .a(a), .b(b),
    .y_nand(y_nand), .y_nor(y_nor), .y_xor(y_xor), .y_xnor(y_xnor),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt)
`ifdef GATE_BIST_ERRLOG_EN
    , .err_valid(err_valid), .err_op(err_op), .err_vec(err_vec)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic gold(input int g, input logic x, input logic z);
    case (g)
      0:       return ~(x & z);
      1:       return ~(x | z);
      2:       return x ^ z;
      default: return ~(x ^ z);
    endcase
  endfunction

  function automatic logic faulty(input int g, input logic [1:0] f, input logic x, input logic z);
    case (f)
      2'd0:    return gold(g, x, z);
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return ~gold(g, x, z);
    endcase
  endfunction

  always_comb begin
    y_nand = faulty(0, flt[1:0], a, b);
    y_nor  = faulty(1, flt[3:2], a, b);
    y_xor  = faulty(2, flt[5:4], a, b);
    y_xnor = faulty(3, flt[7:6], a, b);
  end

  // Reference: enumerate all four input pairs and all enabled gates
  function automatic void model(input logic [3:0] m, input logic [7:0] f,
                                output int fc, output int eop, output int evec);
    logic [1:0] fg;
    fc = 0; eop = 0; evec = 0;
    for (int v = 0; v < 4; v++) begin
      for (int g = 0; g < 4; g++) begin
        fg = f[2*g +: 2];
        if (m[g] && (faulty(g, fg, v[1], v[0]) != gold(g, v[1], v[0]))) begin
          if (fc == 0) begin
            eop = g; evec = v;
          end
          fc++;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One run: start accepted on the first posedge; disturbance (start
  // re-pulse plus op_mask change) injected at t == dist_t when dist_t >= 0.
  task automatic run_check(input string tag, input logic [3:0] m, input logic [7:0] f,
                           input int dist_t, input int exp_fail, input int exp_pass,
                           input int exp_eop, input int exp_evec);
    int  t, bcnt;
    bit  abok;
    int  exp_ab;
    @(negedge clk);
    op_mask = m; flt = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0; bcnt = 0; abok = 1'b1;
    while (!done && t < 200) begin
      if (t == dist_t) begin start = 1'b1; op_mask = 4'hF; end
      if (t == dist_t + 1) start = 1'b0;
      exp_ab = (t < RUN_LEN) ? t / (SC + 1) : 0;
      if ({a, b} != 2'(exp_ab)) abok = 1'b0;
      if (busy) bcnt++;
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    chk($sformatf("%s latency", tag), t, RUN_LEN + 1);
    chk($sformatf("%s fail_cnt", tag), int'(fail_cnt), exp_fail);
    chk($sformatf("%s pass", tag), int'(pass), exp_pass);
    chk($sformatf("%s ab_seq_ok", tag), int'(abok), 1);
    chk($sformatf("%s busy_cycles", tag), bcnt, RUN_LEN);
`ifdef GATE_BIST_ERRLOG_EN
    chk($sformatf("%s err_valid", tag), int'(err_valid), (exp_fail != 0) ? 1 : 0);
    if (exp_fail != 0) begin
      chk($sformatf("%s err_op", tag), int'(err_op), exp_eop);
      chk($sformatf("%s err_vec", tag), int'(err_vec), exp_evec);
    end
`else
    if (exp_eop < 0 || exp_evec < 0) $display("note: bad errlog expectation in %s", tag);
`endif
    @(posedge clk); #1;
    chk($sformatf("%s done_one_cycle", tag), int'(done), 0);
    chk($sformatf("%s pass_held", tag), int'(pass), exp_pass);
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [7:0] flt;
    int         fail;
    int         pass;
    int         eop;
    int         evec;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int  fc, eop, evec, cyc;
    bit  saw;
    logic [3:0] rm;
    logic [7:0] rf;

    tbl[0] = '{4'hF,    8'h00, 0,  1, 0, 0};  // all correct
    tbl[1] = '{4'hF,    8'h10, 2,  0, 2, 1};  // xor stuck0
    tbl[2] = '{4'b1011, 8'h10, 0,  1, 0, 0};  // xor stuck0 masked off
    tbl[3] = '{4'hF,    8'hFF, 16, 0, 0, 0};  // all inverted
    tbl[4] = '{4'h0,    8'hFF, 0,  1, 0, 0};  // nothing enabled
    tbl[5] = '{4'hF,    8'h02, 1,  0, 0, 3};  // nand stuck1
    tbl[6] = '{4'b0010, 8'h04, 1,  0, 1, 0};  // nor stuck0
    tbl[7] = '{4'b1100, 8'h80, 2,  0, 3, 1};  // xnor stuck1

    rst = 1'b1; start = 1'b0; op_mask = 4'h0; flt = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", int'({busy, done, pass, fail_cnt, a, b}), 0);
`ifdef GATE_BIST_ERRLOG_EN
    chk("reset err_valid", int'(err_valid), 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_check($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].flt, -1,
                tbl[i].fail, tbl[i].pass, tbl[i].eop, tbl[i].evec);
    end

    // start re-pulse and op_mask change mid-run are ignored
    run_check("disturb", 4'b1011, 8'h10, 3, 0, 1, 0, 0);

    // reset during the third CHECK cycle
    @(negedge clk);
    op_mask = 4'hF; flt = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2 * (SC + 1) + SC) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun reset outputs", int'({busy, done, pass, fail_cnt, a, b}), 0);
    saw = 1'b0;
    for (int k = 0; k < RUN_LEN + 4; k++) begin
      @(posedge clk); #1;
      if (done) saw = 1'b1;
    end
    chk("midrun reset no done", int'(saw), 0);
    run_check("after_reset", 4'hF, 8'h00, -1, 0, 1, 0, 0);

    // start held high: next run begins right after DONE
    @(negedge clk);
    op_mask = 4'hF; flt = 8'h00; start = 1'b1;
    cyc = 0;
    @(posedge clk); #1;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("held start pass", int'(pass), 1);
    @(posedge clk); #1;
    chk("held start pass cleared", int'(pass), 0);
    @(posedge clk); #1;
    chk("held start busy", int'(busy), 1);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("held start second done", int'(done), 1);
    @(posedge clk); #1;

    // randomized runs against the reference model
    for (int r = 0; r < 24; r++) begin
      rm = 4'($urandom_range(0, 15));
      rf = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      model(rm, rf, fc, eop, evec);
      run_check($sformatf("rnd%0d", r), rm, rf, -1, fc, (fc == 0) ? 1 : 0, eop, evec);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gate_bist_ctrl.md
GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, 1, cycles inputs are held before sampling (legal range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a self-test run, sampled only in IDLE.
REQ-005 SHALL have port: op_mask  input  4  gates to check: bit0 nand, bit1 nor, bit2 xor, bit3 xnor.
REQ-006 SHALL have ports: a, b  output  1 each  stimulus driven to all gates under test.
REQ-007 SHALL have ports: y_nand, y_nor, y_xor, y_xnor  input  1 each  gate outputs under test.
REQ-008 SHALL have port: busy  output  1  high from the cycle after start acceptance until DONE exits.
REQ-009 SHALL have port: done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port: pass  output  1  run result, valid from done and held until the next accepted start.
REQ-011 SHALL have port: fail_cnt  output  5  total mismatches in the last run (0..16).

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, CHECK and DONE.
REQ-013 IDLE with start=1 SHALL latch op_mask, clear fail_cnt and pass, set vec=0, and go to SETTLE.
REQ-014 {a,b} SHALL equal the 2-bit vector register vec in SETTLE and CHECK, and 2'b00 in IDLE and DONE.
REQ-015 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-016 CHECK SHALL last one cycle and compare each enabled output against golden: nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b).
REQ-017 CHECK SHALL add the number of mismatching enabled gates (0..4) to fail_cnt; disabled gates SHALL be ignored.
REQ-018 CHECK SHALL go to SETTLE with vec+1 when vec<3, and to DONE when vec==3 (no wrap).
REQ-019 DONE SHALL last one cycle, assert done, set pass=(final fail_cnt==0), then return to IDLE.
REQ-020 done SHALL be asserted exactly 4*(SETTLE_CYCLES+1)+1 rising edges after the edge that samples start.
REQ-021 start SHALL be ignored outside IDLE; start held high SHALL begin a new run in the cycle after DONE.
REQ-022 op_mask==0 SHALL still run all four vectors and end with pass=1 and fail_cnt=0.
REQ-023 Changes to op_mask during a run SHALL have no effect (the latched copy is used).

Reset
REQ-024 rst=1 SHALL force IDLE, vec=0, a=0, b=0, busy=0, done=0, pass=0, fail_cnt=0 on the next rising edge.
REQ-025 Reset mid-run SHALL abort the run with no done pulse and no change to pass beyond clearing it.

Configuration
REQ-026 With GATE_BIST_ERRLOG_EN defined, SHALL add outputs err_valid (1), err_op (2) and err_vec (2).
REQ-027 These outputs SHALL capture the first mismatch of the run: earliest vec, then lowest gate index (nand=0..xnor=3).
REQ-028 They SHALL be cleared on start acceptance and on reset, and held after DONE.
REQ-029 Without GATE_BIST_ERRLOG_EN, these ports and their logic SHALL be absent, with all other behaviour identical.

Verification
REQ-030 Correct gates, op_mask=4'hF, SETTLE_CYCLES=1, start pulse -> done 9 edges later, pass=1, fail_cnt=0, busy high for 8 cycles.
REQ-031 y_xor stuck-at-0, op_mask=4'hF -> fail_cnt=2 (vec 01,10), pass=0; with macro: err_valid=1, err_op=2, err_vec=2'b01.
REQ-032 y_xor stuck-at-0, op_mask=4'b1011 -> pass=1, fail_cnt=0.
REQ-033 All four outputs inverted, op_mask=4'hF -> fail_cnt=16, pass=0.
REQ-034 rst asserted in the third CHECK cycle -> all outputs 0 next cycle, no done; a new start then completes normally.
REQ-035 start re-pulsed while busy, and op_mask changed mid-run -> ignored; the single run reports the original mask's result.
